// File: rtl/circuito_decodificador_funcionalidade.sv
// Function-code decoder: an accepted code 1..7 drives one of the lines A..G for HOLD_CYCLES cycles.
// Optional feature: define DECOD_ERR_COUNT_EN to add a saturating invalid-code counter (err_count).
module circuito_decodificador_funcionalidade #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:2] CF,
  input  logic       cf_valid,
  output logic       cf_ready,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef DECOD_ERR_COUNT_EN
  ,
  output logic [3:0] err_count
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [7:0] LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [6:0] lines, lines_nxt;
  logic       done_nxt, err_nxt;
  logic [2:0] code;

  // CF[0] is the MSB, so a plain same-width copy keeps the numeric code value.
  assign code = CF;

  function automatic logic [6:0] decode(input logic [2:0] c);
    if (c == 3'd0) decode = 7'd0;
    else           decode = 7'd1 << (c - 3'd1);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lines_nxt = lines;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cf_valid) begin
          if (code == 3'd0) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = LOAD;
            lines_nxt = decode(code);
          end
        end
      end
      HOLD: begin
        // Abort wins over a hold that would expire in the same cycle.
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          lines_nxt = 7'd0;
        end else if (cnt == 8'd0) begin
          state_nxt = IDLE;
          lines_nxt = 7'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
        lines_nxt = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      lines <= 7'd0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lines <= lines_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  assign cf_ready = (state == IDLE);
  assign busy     = (state == HOLD);
  assign {G, F, E, D, C, B, A} = lines;

`ifdef DECOD_ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err_count <= 4'd0;
    else if (err && err_count != 4'hF) err_count <= err_count + 4'd1;
  end
`endif

endmodule
